// File: rtl/div_radix2_if.sv
// div_radix2_if: ALU-to-divider request/response bundle
interface div_radix2_if #(parameter int WIDTH = 32);
  logic signed_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic start;
  logic annul;
  logic [2*WIDTH-1:0] result;
  logic ready;
  logic busy;
  modport master (output signed_div, a, b, start, annul, input result, ready, busy);
  modport slave (input signed_div, a, b, start, annul, output result, ready, busy);
endinterface

// File: rtl/div_radix2.sv
// div_radix2: iterative restoring signed/unsigned divider, one quotient bit per clock
module div_radix2 #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  div_radix2_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [2:0] {IDLE, BUSY, FIX, DZERO, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, araw_q, araw_d;
  logic a_neg_q, a_neg_d, b_neg_q, b_neg_d, ready_q, ready_d, busy_q, busy_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [WIDTH:0] upper;
  logic a_neg_in, b_neg_in, ge;
  always_comb begin
    a_neg_in = bus.signed_div & bus.a[WIDTH-1];
    b_neg_in = bus.signed_div & bus.b[WIDTH-1];
    upper = {rem_q, quo_q[WIDTH-1]};
    ge = upper >= {1'b0, dvs_q};
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    araw_d = araw_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    res_d = res_q;
    if (bus.annul) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          a_neg_d = a_neg_in;
          b_neg_d = b_neg_in;
          quo_d = a_neg_in ? -bus.a : bus.a;
          dvs_d = b_neg_in ? -bus.b : bus.b;
          araw_d = bus.a;
          rem_d = '0;
          cnt_d = '0;
          state_d = (bus.b == '0) ? DZERO : BUSY;
        end
        BUSY: begin
          rem_d = ge ? WIDTH'(upper - {1'b0, dvs_q}) : upper[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ge};
          cnt_d = cnt_q + 1'b1;
          state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : BUSY;
        end
        FIX: begin
          res_d = {a_neg_q ? -rem_q : rem_q, (a_neg_q ^ b_neg_q) ? -quo_q : quo_q};
          state_d = DONE;
        end
        DZERO: begin
          res_d = {araw_q, {WIDTH{1'b1}}};
          state_d = DONE;
        end
        DONE: state_d = bus.start ? DONE : IDLE;
        default: state_d = IDLE;
      endcase
    end
    ready_d = state_d == DONE;
    busy_d = state_d == BUSY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      araw_q <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      res_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      araw_q <= araw_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      res_q <= res_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
    end
  end
  assign bus.result = res_q;
  assign bus.ready = ready_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2: scoreboard bench for div_radix2 against an arithmetic reference
module tb_div_radix2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  div_radix2_if bus ();
  div_radix2 dut (.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = '0;
  logic ready_prev = 1'b0;
  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFFFFFF};
    sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst && bus.ready && !ready_prev) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL result unexpected got=%h want=none", bus.result);
      end else check("result", bus.result, exp_q.pop_front());
    end
    check("ready_busy_excl", {63'b0, bus.ready & bus.busy}, 64'd0);
    ready_prev = bus.ready;
  end
  task automatic do_op(input logic sg, input logic [31:0] a, input logic [31:0] b, input int hold);
    int n;
    logic got;
    bus.signed_div = sg;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    exp_q.push_back(model(sg, a, b));
    last_res = model(sg, a, b);
    n = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      tick();
      n++;
      if (n == 1) begin
        bus.a = $urandom;
        bus.b = $urandom;
        bus.signed_div = ~sg;
      end
      got = bus.ready;
    end
    check("latency", 64'(n), (b == 0) ? 64'd2 : 64'd34);
    if (!got) begin
      bus.annul = 1'b1;
      bus.start = 1'b0;
      tick();
      bus.annul = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_ready", {63'b0, bus.ready}, 64'd1);
      check("hold_result", bus.result, last_res);
    end
    bus.start = 1'b0;
    tick();
    check("ready_drop", {63'b0, bus.ready}, 64'd0);
  endtask
  initial begin
    logic [31:0] ra, rb;
    bus.signed_div = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    repeat (3) tick();
    check("reset_result", bus.result, 64'd0);
    check("reset_flags", {62'b0, bus.ready, bus.busy}, 64'd0);
    rst = 1'b0;
    tick();
    do_op(1'b0, 32'd100, 32'd7, 3);
    do_op(1'b1, 32'hFFFFFFF9, 32'd2, 0);
    do_op(1'b1, 32'd7, 32'hFFFFFFFE, 1);
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op(1'b0, 32'hFFFFFFFF, 32'd1, 0);
    do_op(1'b0, 32'h1234, 32'd0, 2);
    do_op(1'b1, 32'h1234, 32'd0, 0);
    bus.a = 32'd50;
    bus.b = 32'd3;
    bus.start = 1'b1;
    repeat (11) tick();
    check("annul_pre_busy", {63'b0, bus.busy}, 64'd1);
    bus.annul = 1'b1;
    bus.start = 1'b0;
    tick();
    bus.annul = 1'b0;
    check("annul_flags", {62'b0, bus.ready, bus.busy}, 64'd0);
    check("annul_result", bus.result, last_res);
    tick();
    do_op(1'b0, 32'd1000, 32'd9, 0);
    bus.start = 1'b1;
    bus.annul = 1'b1;
    tick();
    check("annul_start_idle", {62'b0, bus.ready, bus.busy}, 64'd0);
    bus.start = 1'b0;
    bus.annul = 1'b0;
    tick();
    check("annul_start_idle2", {62'b0, bus.ready, bus.busy}, 64'd0);
    bus.a = 32'd77;
    bus.b = 32'd5;
    bus.start = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    bus.start = 1'b0;
    tick();
    check("rst_mid_result", bus.result, 64'd0);
    check("rst_mid_flags", {62'b0, bus.ready, bus.busy}, 64'd0);
    rst = 1'b0;
    last_res = '0;
    tick();
    do_op(1'b1, 32'hFFFFFF9C, 32'd7, 0);
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(0, 15);
        2: rb = 32'(-int'($urandom_range(1, 9)));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      do_op(1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 2));
    end
    tick();
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
